// File: rtl/bb_controller.sv
// Instruction sequencer for the 10-bit instruction register: steps T0..T3 on the falling clock edge.
// Optional illegal-opcode trap with sticky Err output is enabled by defining BB_ILLEGAL_TRAP_EN.
module bb_controller #(
    parameter int IW   = 10,
    parameter int NREG = 4
) (
    input  logic            CLKb,
    input  logic            Rstb,
    input  logic            Exec,
    input  logic [IW-1:0]   Instr,
    output logic            IR_EN,
    output logic            Ext,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [3:0]      ALUcont,
    output logic            Done,
    output logic [1:0]      Tstep
`ifdef BB_ILLEGAL_TRAP_EN
    ,
    output logic            Err
`endif
);

    typedef enum logic [1:0] {
        ST_T0 = 2'd0,
        ST_T1 = 2'd1,
        ST_T2 = 2'd2,
        ST_T3 = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MOV  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0110;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      w_op;
    logic [1:0]      w_rx;
    logic [1:0]      w_ry;
    logic            w_alu;
    logic            w_halt;
    logic            w_unused_rsvd;
`ifdef BB_ILLEGAL_TRAP_EN
    logic            r_err;
    logic            w_set_err;
`endif

    function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    assign w_op          = Instr[9:6];
    assign w_rx          = Instr[5:4];
    assign w_ry          = Instr[3:2];
    assign w_alu         = is_alu_op(w_op);
    assign w_unused_rsvd = ^Instr[1:0];
    assign Tstep         = r_state;

`ifdef BB_ILLEGAL_TRAP_EN
    assign w_halt = r_err;
    assign Err    = r_err;
`else
    assign w_halt = 1'b0;
`endif

    // Next-step selection and per-step control decode; reset masks every control output.
    always_comb begin
        w_next  = ST_T0;
        IR_EN   = 1'b0;
        Ext     = 1'b0;
        Rin     = '0;
        Rout    = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        ALUcont = 4'b0000;
        Done    = 1'b0;
`ifdef BB_ILLEGAL_TRAP_EN
        w_set_err = 1'b0;
`endif
        if (!Rstb) begin
            w_next = ST_T0;
        end else begin
            case (r_state)
                ST_T0: begin
                    IR_EN  = Exec & ~w_halt;
                    w_next = (Exec & ~w_halt) ? ST_T1 : ST_T0;
                end
                ST_T1: begin
                    if (w_op == OP_LOAD) begin
                        Ext    = 1'b1;
                        Rin    = onehot(w_rx);
                        Done   = 1'b1;
                        w_next = ST_T0;
                    end else if (w_op == OP_MOV) begin
                        Rout   = onehot(w_ry);
                        Rin    = onehot(w_rx);
                        Done   = 1'b1;
                        w_next = ST_T0;
                    end else if (w_alu) begin
                        Rout   = onehot(w_rx);
                        Ain    = 1'b1;
                        w_next = ST_T2;
                    end else begin
                        // Illegal opcode retires as a bus-silent NOP.
                        Done   = 1'b1;
                        w_next = ST_T0;
`ifdef BB_ILLEGAL_TRAP_EN
                        w_set_err = 1'b1;
`endif
                    end
                end
                ST_T2: begin
                    if (w_alu) begin
                        Rout    = onehot(w_ry);
                        Gin     = 1'b1;
                        ALUcont = w_op;
                        w_next  = ST_T3;
                    end else begin
                        w_next = ST_T0;
                    end
                end
                ST_T3: begin
                    if (w_alu) begin
                        Gout   = 1'b1;
                        Rin    = onehot(w_rx);
                        Done   = 1'b1;
                        w_next = ST_T0;
                    end else begin
                        w_next = ST_T0;
                    end
                end
                default: begin
                    w_next = ST_T0;
                end
            endcase
        end
    end

    // Timestep register, shares the instruction register's falling edge.
    always_ff @(negedge CLKb) begin
        if (!Rstb) begin
            r_state <= ST_T0;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef BB_ILLEGAL_TRAP_EN
    // Sticky trap flag; only reset clears it.
    always_ff @(negedge CLKb) begin
        if (!Rstb) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end
`endif

endmodule

// File: doc/bb_controller.md
Name: bb_controller

Overview:
Instruction sequencer directly downstream of the 10-bit instruction register. Its IR_EN output loads that register at timestep T0, and it decodes the register's Q output. It then steps through timesteps T0..T3, driving register-file, accumulator (A), ALU-result (G) and bus control signals for each step. One instruction completes per pass, after which the sequencer returns to T0 for the next fetch.

Parameters:
IW, 10, instruction width; fixed by encoding, no other value supported.
NREG, 4, number of general registers; one-hot select width; fixed by 2-bit register fields.

Ports:
CLKb  in  1  clock; all state updates on falling edge (matches instruction register).
Rstb  in  1  synchronous active-low reset, sampled on falling edge of CLKb.
Exec  in  1  start request; sampled only in T0.
Instr  in  IW  instruction from instruction register Q.
IR_EN  out  1  instruction register load enable.
Ext  out  1  drive external data bus onto internal bus (LOAD immediate).
Rin  out  NREG  one-hot register write enable.
Rout  out  NREG  one-hot register bus drive.
Ain  out  1  load accumulator A.
Gin  out  1  load ALU result register G.
Gout  out  1  drive G onto bus.
ALUcont  out  4  ALU operation code.
Done  out  1  last step of instruction.
Tstep  out  2  current timestep (T0=0..T3=3).

Behaviour:
- Encoding: Instr[9:6] opcode, Instr[5:4] Rx, Instr[3:2] Ry, Instr[1:0] reserved (ignored).
- Opcodes: 0000 LOAD Rx<-ext; 0001 MOV Rx<-Ry; 0010 ADD; 0011 SUB; 0100 AND; 0101 OR; 0110 XOR (all Rx<-Rx op Ry); 1000-1111 and 0111 illegal.
- Timestep counter is the only state besides the optional error flag. Tstep register encodes the step directly.
- Reset: Rstb=0 at a falling edge forces Tstep=0 and clears the error flag. While Rstb=0, all control outputs are forced 0, including IR_EN.
- Reset mid-instruction aborts it with no Done pulse.
- All control outputs are combinational from Tstep, Instr and Exec. Every output is 0 unless listed below.
- T0: IR_EN=Exec.
  - Exec=1: next Tstep=1. The instruction register captures on the same falling edge.
  - Exec=0: stay at T0.
  - Exec is ignored in T1..T3.
- T1:
  - LOAD: Ext=1, Rin=onehot(Rx), Done=1, next T0.
  - MOV: Rout=onehot(Ry), Rin=onehot(Rx), Done=1, next T0.
  - ALU ops: Rout=onehot(Rx), Ain=1, next T2.
  - Illegal: Done=1, next T0; no register/bus activity (NOP).
- T2 (ALU ops): Rout=onehot(Ry), Gin=1, ALUcont=opcode, next T3.
- T3 (ALU ops): Gout=1, Rin=onehot(Rx), Done=1, next T0.
- ALUcont=0000 outside T2.
- Latency in cycles, T0 included: LOAD/MOV/illegal 2; ALU ops 4.
- Exec held high gives back-to-back instructions with no idle cycle; the cycle after Done is the next T0 fetch.
- MOV with Rx=Ry is legal; Rin and Rout assert the same bit.
- Invariant: at most one bus driver (Ext, any Rout bit, Gout) active in any cycle.
- Tstep never reaches a value outside its opcode's sequence. Defensive default: any unexpected state returns to T0 with all outputs 0.

Optional Feature:
Macro BB_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output Err (1 bit).
  - An illegal opcode in T1 sets Err on that falling edge. Err is sticky until Rstb=0.
  - While Err=1, T0 holds IR_EN=0 and ignores Exec (processor halts).
- Undefined: illegal opcodes are 2-cycle NOPs; no Err port.

Test Plan:
- Rstb=0 for 2 edges with Exec=1 -> Tstep=0, IR_EN=0, all outputs 0. Release with Exec=0 -> stays T0, IR_EN=0.
- Exec=1, Instr=10'b0000_10_00_00 (LOAD R2) -> T0: IR_EN=1. T1: Ext=1, Rin=0100, Done=1. Next cycle T0.
- Instr=10'b0010_01_10_00 (ADD R1,R2) ->
  - T1: Rout=0010, Ain=1.
  - T2: Rout=0100, Gin=1, ALUcont=0010.
  - T3: Gout=1, Rin=0010, Done=1.
  - Bench checks exactly 4 cycles and one-hot bus drive every cycle.
- Exec held 1: MOV R3,R0 then SUB R0,R3 -> Done at cycles 2 and 6. MOV T1: Rout=0001, Rin=1000. SUB T2: ALUcont=0011.
- Rstb=0 during T2 of XOR -> next edge Tstep=0, no Done, Rin never asserted.
- Instr opcode 1010 -> T1: Done=1, Rin=0, Rout=0. With BB_ILLEGAL_TRAP_EN: Err=1, subsequent Exec=1 gives IR_EN=0 until reset.
